// File: rtl/mcs6530_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mcs6530_bus_arbiter
//
// Shares the single mcs6530 bus port between the 6502 CPU and a host/debug
// loader. The CPU has priority. A pending host request may lose at most
// MAX_WAIT consecutive cycles to the CPU before it is forced through. At most
// one access is issued per cycle. Read data returns to whichever master
// issued the access. Everything runs on phi2, the same clock as the 6530.
//
// Parameters
//   MAX_WAIT    most consecutive CPU-won cycles a pending host request can
//               lose (1..15)
//
// Ports
//   phi2        clock, rising-edge active
//   rst         asynchronous active-high reset
//   cpu_req     CPU presents an access this cycle
//   cpu_we_n    CPU write enable, active low
//   cpu_rs0     CPU RAM/ROM select
//   cpu_cs1     CPU chip select
//   cpu_a       CPU address
//   cpu_di      CPU write data
//   cpu_rdy     CPU access issued this cycle; when low the CPU holds its access
//   cpu_do      CPU read data (mirror of m_do)
//   cpu_dvalid  cpu_do is valid this cycle
//   host_req    host request, held together with its fields until host_ack
//   host_we_n   host write enable, active low
//   host_rs0    host RAM/ROM select
//   host_cs1    host chip select
//   host_a      host address
//   host_di     host write data
//   host_ack    one-cycle completion pulse for the host
//   host_do     host read data, valid while host_ack is high
//   m_a         address to the 6530
//   m_we_n      write enable to the 6530
//   m_rs0       RAM/ROM select to the 6530
//   m_cs1       chip select to the 6530
//   m_di        write data to the 6530
//   m_do        read data from the 6530
//   m_oe        output enable from the 6530 (m_do is driven)
// ----------------------------------------------------------------------------
module mcs6530_bus_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic       phi2,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we_n,
  input  logic       cpu_rs0,
  input  logic       cpu_cs1,
  input  logic [9:0] cpu_a,
  input  logic [7:0] cpu_di,
  output logic       cpu_rdy,
  output logic [7:0] cpu_do,
  output logic       cpu_dvalid,
  input  logic       host_req,
  input  logic       host_we_n,
  input  logic       host_rs0,
  input  logic       host_cs1,
  input  logic [9:0] host_a,
  input  logic [7:0] host_di,
  output logic       host_ack,
  output logic [7:0] host_do,
  output logic [9:0] m_a,
  output logic       m_we_n,
  output logic       m_rs0,
  output logic       m_cs1,
  output logic [7:0] m_di,
  input  logic [7:0] m_do,
  input  logic       m_oe
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HCAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] waitCnt_q, waitCnt_d;
  logic          hostAck_q, hostAck_d;
  logic [7:0]    hostDo_q, hostDo_d;
  logic          cpuDvalid_q, cpuDvalid_d;
  logic          hostGnt;

  // Grant decision. The host is blocked during its capture cycle and during
  // its ack cycle, so its next grant is at least three cycles after the last
  // one. Otherwise it wins when the CPU is idle or when it has already lost
  // MAX_WAIT cycles. Both grants are forced low while reset is asserted so
  // the bus goes idle immediately.
  always_comb begin
    hostGnt = host_req & ~hostAck_q & (state_q != S_HCAP) &
              (~cpu_req | (waitCnt_q == MAX_CNT)) & ~rst;
    cpu_rdy = cpu_req & ~hostGnt & ~rst;
  end

  // Bus multiplexer. With no access issued, the bus is parked on values
  // that select no 6530 resource.
  always_comb begin
    m_a    = 10'h000;
    m_we_n = 1'b1;
    m_rs0  = 1'b0;
    m_cs1  = 1'b0;
    m_di   = 8'h00;
    if (hostGnt) begin
      m_a    = host_a;
      m_we_n = host_we_n;
      m_rs0  = host_rs0;
      m_cs1  = host_cs1;
      m_di   = host_di;
    end else if (cpu_rdy) begin
      m_a    = cpu_a;
      m_we_n = cpu_we_n;
      m_rs0  = cpu_rs0;
      m_cs1  = cpu_cs1;
      m_di   = cpu_di;
    end
  end

  // Host sequencing. WAIT counts the cycles the host has lost to the CPU.
  // HCAP is the cycle after the host grant, when the 6530 presents the data
  // for the host access. That data is captured there, or 8'hFF is captured
  // when the 6530 does not drive the bus. The ack follows one cycle later.
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    hostAck_d   = 1'b0;
    hostDo_d    = hostDo_q;
    cpuDvalid_d = cpu_rdy & cpu_we_n;
    case (state_q)
      S_IDLE: begin
        if (hostGnt) begin
          state_d   = S_HCAP;
          waitCnt_d = '0;
        end else if (host_req & ~hostAck_q & cpu_rdy) begin
          state_d   = S_WAIT;
          waitCnt_d = CW'(1);
        end
      end
      S_WAIT: begin
        if (hostGnt) begin
          state_d   = S_HCAP;
          waitCnt_d = '0;
        end else if (~host_req) begin
          state_d   = S_IDLE;
          waitCnt_d = '0;
        end else if (waitCnt_q != MAX_CNT) begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
      end
      S_HCAP: begin
        hostAck_d = 1'b1;
        hostDo_d  = m_oe ? m_do : 8'hFF;
        state_d   = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        waitCnt_d = '0;
      end
    endcase
  end

  // State registers. An asynchronous reset drops any host access in flight,
  // so no ack is ever issued for it.
  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      waitCnt_q   <= '0;
      hostAck_q   <= 1'b0;
      hostDo_q    <= 8'h00;
      cpuDvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      hostAck_q   <= hostAck_d;
      hostDo_q    <= hostDo_d;
      cpuDvalid_q <= cpuDvalid_d;
    end
  end

  // CPU read data arrives one cycle after the access is issued. It is only
  // marked valid when the 6530 is actually driving the bus.
  always_comb begin
    cpu_do     = m_do;
    cpu_dvalid = cpuDvalid_q & m_oe;
    host_ack   = hostAck_q;
    host_do    = hostDo_q;
  end

endmodule

// File: tb/tb_mcs6530_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mcs6530_bus_arbiter
//
// Directed bench for mcs6530_bus_arbiter with MAX_WAIT = 4. A small 6530
// stand-in is attached. The stand-in answers with registered read data one
// cycle after a selected read, and leaves OE low for writes and unselected
// cycles. Inputs are driven 1 time unit after the rising edge of phi2.
// Outputs are sampled after the inputs settle.
// ----------------------------------------------------------------------------
module tb_mcs6530_bus_arbiter;

  logic       phi2 = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we_n, cpu_rs0, cpu_cs1;
  logic [9:0] cpu_a;
  logic [7:0] cpu_di;
  logic       cpu_rdy;
  logic [7:0] cpu_do;
  logic       cpu_dvalid;
  logic       host_req, host_we_n, host_rs0, host_cs1;
  logic [9:0] host_a;
  logic [7:0] host_di;
  logic       host_ack;
  logic [7:0] host_do;
  logic [9:0] m_a;
  logic       m_we_n, m_rs0, m_cs1;
  logic [7:0] m_di;
  logic [7:0] m_do;
  logic       m_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];

  mcs6530_bus_arbiter #(.MAX_WAIT(4)) dut (
    .phi2       (phi2),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we_n   (cpu_we_n),
    .cpu_rs0    (cpu_rs0),
    .cpu_cs1    (cpu_cs1),
    .cpu_a      (cpu_a),
    .cpu_di     (cpu_di),
    .cpu_rdy    (cpu_rdy),
    .cpu_do     (cpu_do),
    .cpu_dvalid (cpu_dvalid),
    .host_req   (host_req),
    .host_we_n  (host_we_n),
    .host_rs0   (host_rs0),
    .host_cs1   (host_cs1),
    .host_a     (host_a),
    .host_di    (host_di),
    .host_ack   (host_ack),
    .host_do    (host_do),
    .m_a        (m_a),
    .m_we_n     (m_we_n),
    .m_rs0      (m_rs0),
    .m_cs1      (m_cs1),
    .m_di       (m_di),
    .m_do       (m_do),
    .m_oe       (m_oe)
  );

  // Free-running phi2, 10 time units per cycle.
  always #5 phi2 = ~phi2;

  // 6530 stand-in. A selected read returns the stored byte in the next
  // cycle with OE high. A selected write stores the byte. Writes and
  // unselected cycles leave OE low.
  always @(posedge phi2 or posedge rst) begin
    if (rst) begin
      m_do <= 8'h00;
      m_oe <= 1'b0;
    end else if (m_rs0 | m_cs1) begin
      if (!m_we_n) begin
        mem[m_a] <= m_di;
        m_oe     <= 1'b0;
      end else begin
        m_do <= mem[m_a];
        m_oe <= 1'b1;
      end
    end else begin
      m_oe <= 1'b0;
    end
  end

  task automatic nextCycle();
    @(posedge phi2);
    #1;
  endtask

  task automatic applyCpuStimulus(input logic req, input logic weN,
                                  input logic rs0, input logic cs1,
                                  input logic [9:0] a, input logic [7:0] d);
    cpu_req  = req;
    cpu_we_n = weN;
    cpu_rs0  = rs0;
    cpu_cs1  = cs1;
    cpu_a    = a;
    cpu_di   = d;
  endtask

  task automatic applyHostStimulus(input logic req, input logic weN,
                                   input logic rs0, input logic cs1,
                                   input logic [9:0] a, input logic [7:0] d);
    host_req  = req;
    host_we_n = weN;
    host_rs0  = rs0;
    host_cs1  = cs1;
    host_a    = a;
    host_di   = d;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Directed sequence. Cycle names in the comments count rising edges from
  // the first cycle of each scenario.
  initial begin
    rst = 1'b1;
    applyCpuStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    applyHostStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);

    // Reset values while rst is held.
    nextCycle();
    checkOutput("rst_cpu_rdy",    16'(cpu_rdy),    16'h0);
    checkOutput("rst_host_ack",   16'(host_ack),   16'h0);
    checkOutput("rst_host_do",    16'(host_do),    16'h00);
    checkOutput("rst_cpu_dvalid", 16'(cpu_dvalid), 16'h0);
    checkOutput("rst_m_we_n",     16'(m_we_n),     16'h1);
    checkOutput("rst_m_rs0",      16'(m_rs0),      16'h0);
    nextCycle();
    rst = 1'b0;
    #1;

    // CPU write of 8'h5A to 10'h3C5. This seeds the read that follows.
    applyCpuStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h3C5, 8'h5A);
    #1;
    checkOutput("cpuwr_rdy",  16'(cpu_rdy), 16'h1);
    checkOutput("cpuwr_we_n", 16'(m_we_n),  16'h0);
    checkOutput("cpuwr_m_di", 16'(m_di),    16'h5A);
    nextCycle();
    applyCpuStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    #1;
    checkOutput("cpuwr_no_dvalid", 16'(cpu_dvalid), 16'h0);

    // CPU read of RAM at 10'h3C5. N: issue. N+1: data 8'h5A.
    applyCpuStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h3C5, 8'h00);
    #1;
    checkOutput("cpurd_rdy", 16'(cpu_rdy), 16'h1);
    checkOutput("cpurd_m_a", 16'(m_a),     16'h3C5);
    nextCycle();
    checkOutput("cpurd_dvalid", 16'(cpu_dvalid), 16'h1);
    checkOutput("cpurd_do",     16'(cpu_do),     16'h5A);
    applyCpuStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    nextCycle();
    checkOutput("cpurd_dvalid_drop", 16'(cpu_dvalid), 16'h0);

    // Host write of 8'hA5 to 10'h3C0. N: grant. N+1: capture. N+2: ack.
    applyHostStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h3C0, 8'hA5);
    #1;
    checkOutput("hwr_we_n", 16'(m_we_n), 16'h0);
    checkOutput("hwr_m_a",  16'(m_a),    16'h3C0);
    checkOutput("hwr_m_di", 16'(m_di),   16'hA5);
    nextCycle();
    checkOutput("hwr_hcap_ack",   16'(host_ack), 16'h0);
    checkOutput("hwr_hcap_idle",  16'(m_rs0),    16'h0);
    nextCycle();
    checkOutput("hwr_ack", 16'(host_ack), 16'h1);
    checkOutput("hwr_do",  16'(host_do),  16'hFF);
    applyHostStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    nextCycle();
    checkOutput("hwr_ack_pulse", 16'(host_ack), 16'h0);

    // Host read of 10'h3C0. The request is still held in the ack cycle and
    // must not be granted again there.
    applyHostStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h3C0, 8'h00);
    #1;
    checkOutput("hrd_rs0", 16'(m_rs0), 16'h1);
    checkOutput("hrd_m_a", 16'(m_a),   16'h3C0);
    nextCycle();
    checkOutput("hrd_hcap_ack", 16'(host_ack), 16'h0);
    nextCycle();
    checkOutput("hrd_ack",        16'(host_ack), 16'h1);
    checkOutput("hrd_do",         16'(host_do),  16'hA5);
    checkOutput("hrd_ack_no_gnt", 16'(m_rs0),    16'h0);
    applyHostStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    nextCycle();
    checkOutput("hrd_ack_pulse", 16'(host_ack), 16'h0);

    // Starvation bound with an unmapped host read. CPU held busy. Host
    // raised at K. CPU wins K..K+3, host wins K+4, ack at K+6 with 8'hFF.
    applyCpuStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h3C5, 8'h00);
    applyHostStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'h155, 8'h00);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("starve_cpu_rdy_k%0d", i), 16'(cpu_rdy), 16'h1);
      checkOutput($sformatf("starve_m_a_k%0d", i),     16'(m_a),     16'h3C5);
      nextCycle();
    end
    checkOutput("starve_k4_cpu_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("starve_k4_m_a",     16'(m_a),     16'h155);
    checkOutput("starve_k4_m_rs0",   16'(m_rs0),   16'h0);
    checkOutput("starve_k4_m_cs1",   16'(m_cs1),   16'h0);
    nextCycle();
    checkOutput("starve_k5_cpu_rdy", 16'(cpu_rdy),  16'h1);
    checkOutput("starve_k5_ack",     16'(host_ack), 16'h0);
    nextCycle();
    checkOutput("starve_k6_ack",     16'(host_ack), 16'h1);
    checkOutput("unmapped_host_do",  16'(host_do),  16'hFF);
    checkOutput("starve_k6_cpu_rdy", 16'(cpu_rdy),  16'h1);
    applyCpuStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    applyHostStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    nextCycle();
    checkOutput("starve_ack_pulse", 16'(host_ack), 16'h0);

    // Abandon. The host loses two cycles in WAIT, then drops its request.
    // No ack may follow.
    applyCpuStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h3C5, 8'h00);
    applyHostStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h3C0, 8'h00);
    #1;
    checkOutput("abandon_j0_cpu_rdy", 16'(cpu_rdy), 16'h1);
    nextCycle();
    checkOutput("abandon_j1_cpu_rdy", 16'(cpu_rdy), 16'h1);
    nextCycle();
    applyHostStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    #1;
    checkOutput("abandon_j2_cpu_rdy", 16'(cpu_rdy), 16'h1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput($sformatf("abandon_no_ack_%0d", i), 16'(host_ack), 16'h0);
      checkOutput($sformatf("abandon_cpu_rdy_%0d", i), 16'(cpu_rdy), 16'h1);
    end

    // Fresh request after the abandon. The full wait must be served again.
    // Reset then hits during HCAP, and the access must never be acked.
    applyHostStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h3C0, 8'h00);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rewait_cpu_rdy_l%0d", i), 16'(cpu_rdy), 16'h1);
      nextCycle();
    end
    checkOutput("rewait_l4_cpu_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("rewait_l4_m_a",     16'(m_a),     16'h3C0);
    nextCycle();
    checkOutput("hcap_before_rst_ack", 16'(host_ack), 16'h0);
    checkOutput("hcap_cpu_rdy",        16'(cpu_rdy),  16'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_cpu_rdy",  16'(cpu_rdy),  16'h0);
    checkOutput("midrst_m_rs0",    16'(m_rs0),    16'h0);
    checkOutput("midrst_m_cs1",    16'(m_cs1),    16'h0);
    checkOutput("midrst_m_we_n",   16'(m_we_n),   16'h1);
    checkOutput("midrst_m_a",      16'(m_a),      16'h000);
    checkOutput("midrst_host_ack", 16'(host_ack), 16'h0);
    checkOutput("midrst_host_do",  16'(host_do),  16'h00);
    applyCpuStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    applyHostStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput($sformatf("postrst_no_ack_%0d", i), 16'(host_ack), 16'h0);
    end

    // After reset the arbiter is idle, so a lone host read is granted at
    // once and acked two cycles later.
    applyHostStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h3C0, 8'h00);
    #1;
    checkOutput("postrst_gnt_m_a", 16'(m_a), 16'h3C0);
    nextCycle();
    nextCycle();
    checkOutput("postrst_ack", 16'(host_ack), 16'h1);
    checkOutput("postrst_do",  16'(host_do),  16'hA5);
    applyHostStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 8'h00);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
